// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the matrix scanner and its consumer.
// master = scanner side, slave = pins/code-entry side.
interface keypad_if;
  logic [3:0] fila;
  logic [2:0] columna;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  fila,
    output columna,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output fila,
    input  columna,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, row synchronizer,
// press/release debounce and one registered key event per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE_N = 500000
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(DEBOUNCE_N);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX = BW'(DEBOUNCE_N - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    columna_q, columna_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic [3:0] rows;
  logic       rows_one_hot;
  logic [2:0] col_next;

  function automatic logic [3:0] key_map(
    input logic [3:0] r,
    input logic [2:0] c
  );
    logic [3:0] ri;
    logic [3:0] ci;
    logic [3:0] code;
    ri = 4'd0;
    ci = 4'd0;
    code = 4'd0;
    unique case (1'b1)
      r[1]:    ri = 4'd1;
      r[2]:    ri = 4'd2;
      r[3]:    ri = 4'd3;
      default: ri = 4'd0;
    endcase
    unique case (1'b1)
      c[1]:    ci = 4'd1;
      c[2]:    ci = 4'd2;
      default: ci = 4'd0;
    endcase
    // Bottom row carries the symbols around the zero key
    if (ri == 4'd3) begin
      unique case (ci)
        4'd0:    code = 4'hA;
        4'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = ri * 4'd3 + ci + 4'd1;
    end
    return code;
  endfunction

  assign rows = sync2_q;
  assign rows_one_hot = (rows != 4'd0) &&
                        ((rows & (rows - 4'd1)) == 4'd0);
  assign col_next = {columna_q[1:0], columna_q[2]};

  always_comb begin
    sync1_d     = kp.fila;
    sync2_d     = sync1_q;
    state_d     = state_q;
    div_d       = div_q;
    deb_d       = deb_q;
    row_d       = row_q;
    columna_d   = columna_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (rows_one_hot) begin
            row_d   = rows;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            columna_d = col_next;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows == row_q) begin
          if (deb_q == DEB_MAX) begin
            key_code_d  = key_map(row_q, columna_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            deb_d       = '0;
            state_d     = HELD;
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end else begin
          deb_d     = '0;
          columna_d = col_next;
          state_d   = SCAN;
        end
      end
      HELD: begin
        if (rows == 4'd0) begin
          if (deb_q == DEB_MAX) begin
            key_held_d = 1'b0;
            deb_d      = '0;
            columna_d  = col_next;
            state_d    = SCAN;
          end else begin
            deb_d = deb_q + BW'(1);
          end
        end else begin
          deb_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      sync1_q     <= '0;
      sync2_q     <= '0;
      div_q       <= '0;
      deb_q       <= '0;
      row_q       <= '0;
      columna_q   <= 3'b001;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      row_q       <= row_d;
      columna_q   <= columna_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.columna   = columna_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
